// File: rtl/inst_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer.
// Holds the state enum, inst bit positions and width constants.
package inst_sequencer_pkg;

   localparam int inst_width = 17;
   localparam int addr_w     = 4;
   localparam int cnt_w      = 16;

   localparam int bit_ofifo_rd = 16;
   localparam int bit_qkmem_lo = 12;
   localparam int bit_pmem_lo  = 8;
   localparam int bit_execute  = 7;
   localparam int bit_load     = 6;
   localparam int bit_qmem_rd  = 5;
   localparam int bit_qmem_wr  = 4;
   localparam int bit_kmem_rd  = 3;
   localparam int bit_kmem_wr  = 2;
   localparam int bit_pmem_rd  = 1;
   localparam int bit_pmem_wr  = 0;

   typedef enum logic [2:0] {
      st_idle,
      st_load,
      st_gap1,
      st_exec,
      st_gap2,
      st_drain,
      st_done
   } state_t;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter with a terminal (zero) flag for phase lengths.
// Ports: clk, reset (sync, high), load/load_val, dec -> count, zero.
module phase_counter
   import inst_sequencer_pkg::*;
#(
   parameter int w = cnt_w
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [w-1:0] load_val,
   input  logic         dec,
   output logic [w-1:0] count,
   output logic         zero
);

   assign zero = (count == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !zero) begin
         count <= count - w'(1);
      end
   end

endmodule

// File: rtl/inst_sequencer.sv
// Load / gap / execute / gap / drain instruction sequencer for fullchip.
// Ports: clk, reset, start, num_q, ofifo_valid, host_inst -> inst, busy, done.
module inst_sequencer
   import inst_sequencer_pkg::*;
#(
   parameter int col        = 8,
   parameter int gap_cycles = 10,
   parameter int inst_w     = inst_width
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        num_q,
   input  logic              ofifo_valid,
   input  logic [inst_w-1:0] host_inst,
   output logic [inst_w-1:0] inst,
   output logic              busy,
   output logic              done
);

   localparam int gap_ld = (gap_cycles > 0) ? gap_cycles - 1 : 0;

   state_t              state_q;
   state_t              state_d;
   logic [inst_w-1:0]   inst_d;
   logic                busy_d;
   logic                done_d;
   logic [addr_w-1:0]   addr_q;
   logic [addr_w-1:0]   addr_d;
   logic [3:0]          nm1_q;
   logic [3:0]          nm1_d;

   logic                cnt_load;
   logic                cnt_dec;
   logic [cnt_w-1:0]    cnt_val;
   logic [cnt_w-1:0]    cnt_q;
   logic                cnt_zero;

   phase_counter #(
      .w (cnt_w)
   ) u_phase_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .count    (cnt_q),
      .zero     (cnt_zero)
   );

   // The state register names the phase whose word is on inst now;
   // the last cycle of each phase produces the first word of the next.
   always_comb begin
      state_d  = state_q;
      inst_d   = '0;
      addr_d   = addr_q;
      nm1_d    = nm1_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = '0;

      unique case (state_q)
         st_idle: begin
            if (start) begin
               state_d          = st_load;
               nm1_d            = num_q;
               addr_d           = '0;
               cnt_load         = 1'b1;
               cnt_val          = cnt_w'(col + 1);
               inst_d[bit_load] = 1'b1;
            end else begin
               inst_d = host_inst;
            end
         end

         st_load: begin
            if (cnt_zero) begin
               state_d  = st_gap1;
               addr_d   = '0;
               cnt_load = 1'b1;
               cnt_val  = cnt_w'(gap_ld);
            end else begin
               cnt_dec          = 1'b1;
               inst_d[bit_load] = 1'b1;
               // count==1 leaves the trailing load-only word
               if (cnt_q != cnt_w'(1)) begin
                  inst_d[bit_kmem_rd] = 1'b1;
                  inst_d[bit_qkmem_lo +: addr_w] = addr_q;
                  addr_d = addr_q + addr_w'(1);
               end
            end
         end

         st_gap1: begin
            if (cnt_zero) begin
               state_d  = st_exec;
               cnt_load = 1'b1;
               cnt_val  = cnt_w'(nm1_q);
               inst_d[bit_execute] = 1'b1;
               inst_d[bit_qmem_rd] = 1'b1;
               inst_d[bit_qkmem_lo +: addr_w] = addr_q;
               addr_d = addr_q + addr_w'(1);
            end else begin
               cnt_dec = 1'b1;
            end
         end

         st_exec: begin
            if (cnt_zero) begin
               state_d  = st_gap2;
               addr_d   = '0;
               cnt_load = 1'b1;
               cnt_val  = cnt_w'(gap_ld);
            end else begin
               cnt_dec = 1'b1;
               inst_d[bit_execute] = 1'b1;
               inst_d[bit_qmem_rd] = 1'b1;
               inst_d[bit_qkmem_lo +: addr_w] = addr_q;
               addr_d = addr_q + addr_w'(1);
            end
         end

         st_gap2: begin
            if (cnt_zero) begin
               // counter holds the number of writes still owed
               state_d  = st_drain;
               cnt_load = 1'b1;
               if (ofifo_valid) begin
                  cnt_val = cnt_w'(nm1_q);
                  inst_d[bit_ofifo_rd] = 1'b1;
                  inst_d[bit_pmem_wr]  = 1'b1;
                  inst_d[bit_pmem_lo +: addr_w] = addr_q;
                  addr_d = addr_q + addr_w'(1);
               end else begin
                  cnt_val = cnt_w'(nm1_q) + cnt_w'(1);
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end

         st_drain: begin
            if (cnt_zero) begin
               state_d = st_done;
            end else if (ofifo_valid) begin
               cnt_dec = 1'b1;
               inst_d[bit_ofifo_rd] = 1'b1;
               inst_d[bit_pmem_wr]  = 1'b1;
               inst_d[bit_pmem_lo +: addr_w] = addr_q;
               addr_d = addr_q + addr_w'(1);
            end
         end

         st_done: begin
            state_d = st_idle;
            addr_d  = '0;
         end

         default: begin
            state_d = st_idle;
         end
      endcase
   end

   assign busy_d = (state_d != st_idle) && (state_d != st_done);
   assign done_d = (state_d == st_done);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= st_idle;
         inst    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         addr_q  <= '0;
         nm1_q   <= '0;
      end else begin
         state_q <= state_d;
         inst    <= inst_d;
         busy    <= busy_d;
         done    <= done_d;
         addr_q  <= addr_d;
         nm1_q   <= nm1_d;
      end
   end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer (col=8, gap_cycles=10).
// Ports driven: clk, reset, start, num_q, ofifo_valid, host_inst.
module tb_inst_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  num_q;
   logic        ofifo_valid;
   logic [16:0] host_inst;
   logic [16:0] inst;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inst_sequencer #(
      .col        (8),
      .gap_cycles (10),
      .inst_w     (17)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num_q       (num_q),
      .ofifo_valid (ofifo_valid),
      .host_inst   (host_inst),
      .inst        (inst),
      .busy        (busy),
      .done        (done)
   );

   function automatic logic [31:0] w_load();
      return 32'h00040;
   endfunction

   function automatic logic [31:0] w_kmem(input int a);
      return 32'h00048 | (32'(a) << 12);
   endfunction

   function automatic logic [31:0] w_exec(input int a);
      return 32'h000A0 | (32'(a) << 12);
   endfunction

   function automatic logic [31:0] w_drain(input int a);
      return 32'h10001 | (32'(a) << 8);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full run; returns in the first IDLE cycle after DONE.
   task automatic do_run(input logic [3:0] nq, input int per,
                         input bit hold);
      int n;
      int j;
      int k;
      bit pv;
      bit ok;
      n = int'(nq) + 1;
      start       = 1'b1;
      num_q       = nq;
      host_inst   = 17'h1FFFF;
      ofifo_valid = 1'b0;
      step();
      if (!hold) start = 1'b0;
      chk("load_first", 32'(inst), w_load());
      chk("busy_first", 32'(busy), 32'd1);
      chk("done_first", 32'(done), 32'd0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("kmem%0d", i), 32'(inst), w_kmem(i));
      end
      step();
      chk("load_last", 32'(inst), w_load());
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("gap1_%0d", i), 32'(inst), 32'd0);
      end
      for (int i = 0; i < n; i++) begin
         step();
         chk($sformatf("exec%0d", i), 32'(inst), w_exec(i));
      end
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("gap2_%0d", i), 32'(inst), 32'd0);
      end
      j  = 0;
      k  = 0;
      pv = ((j % per) == 0);
      ofifo_valid = pv;
      ok = 1'b0;
      for (int g = 0; g < 200; g++) begin
         step();
         if (pv && k < n) begin
            chk($sformatf("drain%0d", k), 32'(inst), w_drain(k));
            k++;
         end else begin
            chk("drain_stall", 32'(inst), 32'd0);
         end
         chk("drain_busy", 32'(busy), 32'd1);
         j++;
         pv = ((j % per) == 0);
         ofifo_valid = pv;
         if (k == n) begin
            ok = 1'b1;
            break;
         end
      end
      chk("drain_count", 32'(k), 32'(n));
      if (ok) begin
         step();
         chk("done_pulse", 32'(done), 32'd1);
         chk("done_inst", 32'(inst), 32'd0);
         chk("done_busy", 32'(busy), 32'd0);
         ofifo_valid = 1'b0;
         step();
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_done", 32'(done), 32'd0);
      end
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b1;
      num_q       = 4'd7;
      ofifo_valid = 1'b1;
      host_inst   = 17'h1FFFF;
      step();
      step();
      chk("rst_inst", 32'(inst), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      reset     = 1'b0;
      start     = 1'b0;
      host_inst = 17'h04000;
      step();
      chk("pass_04000", 32'(inst), 32'h04000);
      chk("pass_busy", 32'(busy), 32'd0);
      host_inst = 17'h00010;
      step();
      chk("pass_00010", 32'(inst), 32'h00010);

      do_run(4'd7, 1, 1'b0);
      host_inst = 17'h00ABC;
      step();
      chk("pass_after_run", 32'(inst), 32'h00ABC);

      do_run(4'd7, 3, 1'b0);

      start       = 1'b1;
      num_q       = 4'd7;
      host_inst   = 17'h1FFFF;
      ofifo_valid = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 22; i++) step();
      chk("mid_exec2", 32'(inst), w_exec(2));
      reset = 1'b1;
      step();
      chk("mid_rst_inst", 32'(inst), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      reset     = 1'b0;
      host_inst = 17'h00123;
      step();
      chk("pass_after_rst", 32'(inst), 32'h00123);
      do_run(4'd7, 1, 1'b0);

      do_run(4'd15, 1, 1'b0);
      do_run(4'd0, 1, 1'b0);

      do_run(4'd3, 1, 1'b1);
      do_run(4'd3, 1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("no_third_run", 32'(busy), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameter col, default 8: number of K vectors loaded into the processor, i.e. the kmem rows read.
REQ-002 Parameter gap_cycles, default 10: number of idle cycles inserted after load and after execute.
REQ-003 Parameter inst_w, default 17: width of the fullchip instruction word.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: request one load/execute/drain run; sampled only in IDLE.
REQ-007 Port num_q, input, 4: number of Q vectors minus one (1..16 vectors); captured with start.
REQ-008 Port ofifo_valid, input, 1: the output FIFO holds at least one entry.
REQ-009 Port host_inst, input, inst_w: host-driven instruction word, passed through while IDLE.
REQ-010 Port inst, output, inst_w, registered: instruction word to fullchip.
- inst bit fields: [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load.
- [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
REQ-011 Port busy, output, 1, registered: sequencer owns inst (any state except IDLE/DONE).
REQ-012 Port done, output, 1, registered: one-cycle pulse at end of a run.

Function
REQ-013 The block SHALL have states IDLE, LOAD, GAP1, EXEC, GAP2, DRAIN, DONE; all outputs registered, so inst in cycle t+1 reflects inputs and state at t.
REQ-014 In IDLE, inst SHALL equal host_inst delayed by one cycle; busy=0, done=0.
REQ-015 If start=1 at cycle T in IDLE, the block SHALL capture N=num_q+1, enter LOAD, and ignore host_inst until back in IDLE.
REQ-016 LOAD sequence:
- cycle T+1: load=1, all other bits 0.
- cycles T+2..T+col+1: load=1, kmem_rd=1, qkmem_add=0..col-1 incrementing.
- cycle T+col+2: load=1, all other bits 0.
REQ-017 GAP1 and GAP2 SHALL each drive inst=0 for exactly gap_cycles cycles.
REQ-018 EXEC SHALL drive execute=1 and qmem_rd=1 for N consecutive cycles with qkmem_add=0..N-1.
REQ-019 DRAIN SHALL keep an index k (0..N-1).
- ofifo_valid=1 at t: cycle t+1 drives ofifo_rd=1, pmem_wr=1, pmem_add=k; k increments.
- ofifo_valid=0 at t: cycle t+1 drives inst=0; k holds.
- DRAIN has no timeout.
REQ-020 After the N-th drain write, the block SHALL spend one cycle in DONE (inst=0, busy=0, done=1), then return to IDLE.
REQ-021 start SHALL be ignored while not in IDLE, and also in the DONE cycle.
REQ-022 Address counters SHALL be 4 bits wide. N=16 wraps qkmem_add and pmem_add from 15 to 0 only at the end of the phase, and the wrap is never driven.
REQ-023 Unused inst bits SHALL be 0 in every sequenced state.

Reset
REQ-024 reset=1 at any rising edge, including mid-run, SHALL force IDLE and inst=0, busy=0, done=0, with all counters and N cleared.
REQ-025 While reset=1, start and host_inst SHALL be ignored. Pass-through resumes on the first cycle after reset deasserts.

Structure
REQ-026 A shared package SHALL hold the state enum, the inst bit-position constants, and the inst_w and address-width constants.
REQ-027 One sub-module, phase_counter, is natural: a loadable down-counter with a terminal flag, reused for LOAD, GAP, EXEC and DRAIN lengths.

Verification
REQ-028 Full run: col=8, gap=10, num_q=7, start at T, ofifo_valid=1 throughout.
- load phase T+1..T+10; kmem_rd at T+2..T+9 with add 0..7.
- zeros T+11..T+20; execute at T+21..T+28 with add 0..7.
- zeros T+29..T+38; drain at T+39..T+46 with pmem_add 0..7.
- done=1 only at T+47.
REQ-029 Stall: ofifo_valid toggles 1,0,0,1,... during DRAIN -> inst=0 on stall cycles, pmem_add sequence still 0..7 without gaps or repeats, done one cycle after the 8th write.
REQ-030 Pass-through: in IDLE, host_inst=0x04000 then 0x00010 -> inst shows the same values one cycle later; during busy, host_inst=0x1FFFF has no effect.
REQ-031 Reset mid-run: reset=1 at the 3rd EXEC cycle -> next cycle inst=0, busy=0. A new start afterwards replays the full sequence from qkmem_add=0.
REQ-032 Boundaries: num_q=15 -> 16 execute cycles with add 0..15. num_q=0 -> single execute and single drain at add 0. start held high through DONE -> exactly one extra run begins from IDLE.
